tcp_tx_sched: RTL

TCP_TX_SCHED -- requirements
Module: tcp_tx_sched

---
 rtl/tcp_pkg.sv | 31 +++
 rtl/tcp_prio_sel.sv | 40 ++++
 rtl/tcp_tx_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tcp_pkg.sv
// Shared definitions for the TCP segment transmit scheduler: FSM state
// encoding, TCP flag layout and the default timing limits.
package tcp_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tcp_state_t;

    // TCP control flags as carried on req_flags_i / snd_flags_o:
    // URG is bit 5 down to FIN at bit 0
    typedef struct packed {
        logic urg;
        logic ack;
        logic psh;
        logic rst;
        logic syn;
        logic fin;
    } tcp_flags_t;

    localparam int FLAGS_W        = $bits(tcp_flags_t);
    localparam int LEN_W          = 16;
    localparam int CNT_W          = 16;
    localparam int STARVE_W       = 3;
    localparam int TIMEOUT_DEF    = 64;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/tcp_prio_sel.sv
// Combinational winner selection: lowest set request index wins, except that
// a starvation override hides index 0 whenever a lower-priority requester
// is also pending.
module tcp_prio_sel
    import tcp_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic             starve,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    logic [NREQ-1:0] mask;
    logic            others;

    assign others = |(req & ~NREQ'(1));

    // Priority encode the (possibly masked) request vector, scanning from the
    // top so the lowest set index is the last one written
    always_comb begin
        mask   = req;
        if (starve && others) begin
            mask = req & ~NREQ'(1);
        end
        valid  = |mask;
        idx    = '0;
        onehot = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx    = IDX_W'(i);
                onehot = NREQ'(1) << i;
            end
        end
    end

endmodule

// File: rtl/tcp_tx_sched.sv
// TCP segment transmit scheduler. Arbitrates NREQ segment requesters onto a
// single frame sender, hands it the winner's flags and length, and tracks the
// sender through busy/idle to report completion or a start-up timeout.
module tcp_tx_sched
    import tcp_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                    CLK_50M,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_i,
    input  logic [FLAGS_W*NREQ-1:0] req_flags_i,
    input  logic [LEN_W*NREQ-1:0]   req_len_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         done_o,
    input  logic                    snd_idle_i,
    output logic                    snd_task_o,
    output logic [FLAGS_W-1:0]      snd_flags_o,
    output logic [LEN_W-1:0]        snd_len_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic [CNT_W-1:0]        frame_cnt_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    tcp_state_t          state;
    logic [TMR_W-1:0]    timer;
    logic [STARVE_W-1:0] starve_cnt;
    logic [NREQ-1:0]     win_oh;
    logic                armed;

    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic [NREQ-1:0]     sel_oh;
    logic                starve;
    logic                others;
    tcp_flags_t          sel_flags;
    logic [LEN_W-1:0]    sel_len;

    // Any requester other than index 0 pending: drives the starvation count
    assign others = |(req_i & ~NREQ'(1));
    assign starve = (starve_cnt == STARVE_W'(STARVE_MAX));

    tcp_prio_sel #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .req    (req_i),
        .starve (starve),
        .valid  (sel_valid),
        .idx    (sel_idx),
        .onehot (sel_oh)
    );

    assign sel_flags = req_flags_i[int'(sel_idx)*FLAGS_W +: FLAGS_W];
    assign sel_len   = req_len_i[int'(sel_idx)*LEN_W +: LEN_W];

    // State is registered, so busy follows it without an extra flop
    assign busy_o = (state != IDLE);

    // Scheduler FSM with registered outputs. 'armed' holds off selection for
    // the first edge after reset release so a launch never lands on it.
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            timer       <= '0;
            starve_cnt  <= '0;
            win_oh      <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            snd_task_o  <= 1'b0;
            snd_flags_o <= '0;
            snd_len_o   <= '0;
            timeout_o   <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            armed      <= 1'b1;
            gnt_o      <= '0;
            done_o     <= '0;
            snd_task_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Grant/task are loaded here so they are high exactly
                    // during the LAUNCH cycle
                    if (armed && snd_idle_i && sel_valid) begin
                        win_oh      <= sel_oh;
                        gnt_o       <= sel_oh;
                        snd_task_o  <= 1'b1;
                        snd_flags_o <= sel_flags;
                        snd_len_o   <= sel_len;
                        timeout_o   <= 1'b0;
                        if (sel_idx != '0) begin
                            starve_cnt <= '0;
                        end else if (others) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Sender must acknowledge by going busy within the window
                    if (!snd_idle_i) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (snd_idle_i) begin
                        done_o      <= win_oh;
                        frame_cnt_o <= frame_cnt_o + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
